// File: rtl/cpe_checker.sv
// Receive-side checker for CPE-protected adder words: recomputes parity from the
// sum bits, forms a syndrome, and tracks a saturating error count plus sticky alarm.
module cpe_checker #(
  parameter int NBIT  = 7,
  parameter int NCODE = 15,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NCODE-1:0] codeword_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBIT-1:0]  data_out,
  output logic [7:0]       syndrome,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic             alarm,
  input  logic             clear
);

  function automatic logic [7:0] parity(input logic [6:0] s);
    logic [7:0] p;
    p[0] = s[0] ^ s[1] ^ s[3];
    p[1] = s[1] ^ s[2] ^ s[4];
    p[2] = s[2] ^ s[3] ^ s[5];
    p[3] = s[3] ^ s[4] ^ s[6];
    p[4] = s[0] ^ s[1] ^ s[3] ^ s[4] ^ s[5];
    p[5] = s[1] ^ s[2] ^ s[4] ^ s[5] ^ s[6];
    p[6] = s[0] ^ s[1] ^ s[2] ^ s[5] ^ s[6];
    p[7] = s[0] ^ s[2] ^ s[6];
    return p;
  endfunction

  logic             en;
  logic             v1;
  logic [NCODE-1:0] r1;
  logic [7:0]       syn_next;
  logic             load_err;

  // The whole pipeline advances together; a stalled output register freezes stage 1 too.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  assign syn_next = r1[NCODE-1:NBIT] ^ parity(r1[NBIT-1:0]);
  assign load_err = en && v1 && (|syn_next);

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      r1        <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      syndrome  <= '0;
      err       <= 1'b0;
    end else if (en) begin
      v1        <= in_valid;
      if (in_valid) r1 <= codeword_in;
      out_valid <= v1;
      if (v1) begin
        data_out <= r1[NBIT-1:0];
        syndrome <= syn_next;
        err      <= |syn_next;
      end
    end
  end

  // clear wins over a simultaneous erroneous load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
      alarm     <= 1'b0;
    end else if (clear) begin
      err_count <= '0;
      alarm     <= 1'b0;
    end else if (load_err) begin
      if (err_count != '1) err_count <= err_count + 1'b1;
      alarm <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpe_checker.sv
// Bench for cpe_checker: directed scenarios plus random traffic, checked against a
// transaction-level model (expected-word queue, mask-based parity, saturating counts).
module tb_cpe_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, clear;
  logic [14:0] codeword_in;
  logic        in_ready, out_valid, err, alarm;
  logic [6:0]  data_out;
  logic [7:0]  syndrome, err_count;
  logic        b_in_ready, b_out_valid, b_err, b_alarm;
  logic [6:0]  b_data_out;
  logic [7:0]  b_syndrome;
  logic [1:0]  b_err_count;

  int checks = 0;
  int errors = 0;

  logic [14:0] exp_q[$];
  int          cnt, cnt2;
  logic        alm;

  cpe_checker #(.NBIT(7), .NCODE(15), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .codeword_in(codeword_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .syndrome(syndrome), .err(err), .err_count(err_count),
    .alarm(alarm), .clear(clear));

  cpe_checker #(.NBIT(7), .NCODE(15), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .codeword_in(codeword_in), .out_valid(b_out_valid), .out_ready(out_ready),
    .data_out(b_data_out), .syndrome(b_syndrome), .err(b_err), .err_count(b_err_count),
    .alarm(b_alarm), .clear(clear));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Each parity bit covers the sum bits selected by its mask.
  function automatic logic [7:0] ref_parity(input logic [6:0] s);
    logic [6:0] masks [8] = '{7'b0001011, 7'b0010110, 7'b0101100, 7'b1011000,
                              7'b0111011, 7'b1110110, 7'b1100111, 7'b1000101};
    logic [7:0] p;
    for (int k = 0; k < 8; k++) p[k] = ^(s & masks[k]);
    return p;
  endfunction

  function automatic logic [7:0] ref_syn(input logic [14:0] cw);
    return cw[14:7] ^ ref_parity(cw[6:0]);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    cnt  = 0;
    cnt2 = 0;
    alm  = 1'b0;
  endtask

  // Drive one cycle from a falling edge, advance to the next falling edge, then check.
  task automatic step(input logic iv, input logic [14:0] cw, input logic ord,
                      input logic clr, output logic acc);
    logic       pov, pir, new_word;
    logic [6:0] pd;
    logic [7:0] ps;
    logic       pe;
    logic [14:0] e;
    in_valid = iv; codeword_in = cw; out_ready = ord; clear = clr;
    #1;
    pov = out_valid; pir = in_ready; pd = data_out; ps = syndrome; pe = err;
    check("in_ready", in_ready, !out_valid || ord);
    @(posedge clk);
    @(negedge clk);
    acc      = iv && pir;
    new_word = out_valid && (!pov || ord);
    if (new_word) begin
      if (exp_q.size() == 0) begin
        check("spurious_word", out_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("data_out", data_out, e[6:0]);
        check("syndrome", syndrome, ref_syn(e));
        check("err", err, |ref_syn(e));
        if (!clr && |ref_syn(e)) begin
          cnt  = (cnt  < 255) ? cnt + 1  : cnt;
          cnt2 = (cnt2 < 3)   ? cnt2 + 1 : cnt2;
          alm  = 1'b1;
        end
      end
    end else if (pov && !ord) begin
      check("stall_valid", out_valid, 1'b1);
      check("stall_data", data_out, pd);
      check("stall_syn", syndrome, ps);
      check("stall_err", err, pe);
    end
    if (clr) begin
      cnt = 0; cnt2 = 0; alm = 1'b0;
    end
    if (acc) exp_q.push_back(cw);
    check("err_count", err_count, cnt);
    check("err_count_sat", b_err_count, cnt2);
    check("alarm", alarm, alm);
    check("alarm_sat", b_alarm, alm);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 15'h0, 1'b1, 1'b0, a);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_data_out"}, data_out, 7'h0);
    check({tag, "_syndrome"}, syndrome, 8'h0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_err_count"}, err_count, 8'h0);
    check({tag, "_alarm"}, alarm, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    logic        acc;
    logic [14:0] words [4];
    logic [6:0]  s;
    logic [14:0] cw;
    int          idx;

    // Reset and idle
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clear = 1'b0; codeword_in = '0;
    model_reset();
    #1;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(10);
    check_zero("idle");

    // Clean words: latency of one edge after acceptance
    step(1'b1, 15'h0000, 1'b1, 1'b0, acc);
    check("clean0_accept", acc, 1'b1);
    check("clean0_early", out_valid, 1'b0);
    step(1'b1, 15'h6881, 1'b1, 1'b0, acc);
    check("clean0_valid", out_valid, 1'b1);
    check("clean0_data", data_out, 7'h00);
    step(1'b0, 15'h0, 1'b1, 1'b0, acc);
    check("clean1_valid", out_valid, 1'b1);
    check("clean1_data", data_out, 7'h01);
    check("clean1_syn", syndrome, 8'h00);
    step(1'b0, 15'h0, 1'b1, 1'b0, acc);
    check("bubble_valid", out_valid, 1'b0);

    // Single-bit faults
    step(1'b1, 15'h6880, 1'b1, 1'b0, acc);
    step(1'b0, 15'h0, 1'b1, 1'b0, acc);
    check("f0_data", data_out, 7'h00);
    check("f0_syn", syndrome, 8'hD1);
    check("f0_err", err, 1'b1);
    check("f0_cnt", err_count, 8'd1);
    check("f0_alarm", alarm, 1'b1);
    step(1'b1, 15'h6981, 1'b1, 1'b0, acc);
    step(1'b0, 15'h0, 1'b1, 1'b0, acc);
    check("f1_syn", syndrome, 8'h02);
    check("f1_cnt", err_count, 8'd2);

    // Backpressure: four words with a three-cycle downstream stall
    words = '{15'h6881, 15'h6880, 15'h0000, 15'h6981};
    idx = 0;
    for (int c = 0; c < 16; c++) begin
      step(idx < 4, (idx < 4) ? words[idx] : 15'h0, !(c >= 2 && c <= 4), 1'b0, acc);
      if (acc) idx++;
    end
    check("bp_all_sent", idx, 4);
    check("bp_drained", exp_q.size(), 0);
    check("bp_cnt", err_count, 8'd4);

    // Saturation of the narrow counter, then clear racing a faulty load
    for (int i = 0; i < 5; i++) step(1'b1, 15'h6880, 1'b1, 1'b0, acc);
    step(1'b0, 15'h0, 1'b1, 1'b0, acc);
    check("sat_narrow", b_err_count, 2'd3);
    check("sat_wide", err_count, 8'd9);
    step(1'b1, 15'h6880, 1'b1, 1'b0, acc);
    step(1'b0, 15'h0, 1'b1, 1'b1, acc);
    check("clr_cnt", err_count, 8'd0);
    check("clr_alarm", alarm, 1'b0);
    check("clr_err_shown", err, 1'b1);
    idle(2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      s  = 7'($urandom);
      cw = {ref_parity(s), s};
      case ($urandom_range(0, 3))
        0: cw[$urandom_range(0, 14)] ^= 1'b1;
        1: begin
          cw[$urandom_range(0, 6)]  ^= 1'b1;
          cw[$urandom_range(7, 14)] ^= 1'b1;
        end
        default: ;
      endcase
      step($urandom_range(0, 3) != 0, cw, $urandom_range(0, 2) != 0,
           $urandom_range(0, 24) == 0, acc);
    end
    idle(3);
    check("rand_drained", exp_q.size(), 0);

    // Asynchronous reset with two words in flight
    step(1'b1, 15'h6880, 1'b1, 1'b0, acc);
    step(1'b1, 15'h6881, 1'b1, 1'b0, acc);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    check("post_rst_valid", out_valid, 1'b0);
    check("post_rst_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpe_checker.md
# cpe_checker

Receiving end of the CPE-protected adder datapath. Accepts 15-bit CPE codewords (7 sum bits plus 8 parity bits) on a valid/ready stream and recomputes the parity from the received sum bits. The recomputed parity is compared against the received parity to form an 8-bit syndrome. Each word is delivered downstream with its syndrome and an error flag through a 2-stage pipeline. A saturating error counter and a sticky alarm are kept for the fault monitor.

## Interface
- NBIT, 7, sum bits per codeword; only 7 is supported.
- NCODE, 15, codeword width (NBIT + 8 parity); only 15 is supported.
- CNT_W, 8, width of the error counter.

- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  codeword_in is valid.
- in_ready  output  1  block accepts codeword_in this cycle.
- codeword_in  input  NCODE  [6:0] sum s, [14:7] parity p[0..7].
- out_valid  output  1  output word is valid.
- out_ready  input  1  downstream accepts the output word.
- data_out  output  NBIT  received sum bits, passed through uncorrected.
- syndrome  output  8  received parity XOR recomputed parity; bit k corresponds to codeword bit 7+k.
- err  output  1  OR-reduction of syndrome.
- err_count  output  CNT_W  number of erroneous words delivered; saturating.
- alarm  output  1  sticky; set by the first erroneous word.
- clear  input  1  synchronous clear of err_count and alarm.

## Operation
- Recomputed parity is a function of s:
  - p0 = s0^s1^s3
  - p1 = s1^s2^s4
  - p2 = s2^s3^s5
  - p3 = s3^s4^s6
  - p4 = s0^s1^s3^s4^s5
  - p5 = s1^s2^s4^s5^s6
  - p6 = s0^s1^s2^s5^s6
  - p7 = s0^s2^s6
- Pipeline has a global enable en = !out_valid | out_ready. in_ready = en, driven combinationally.
- When en is high:
  - Stage 1: v1 <= in_valid; r1 <= codeword_in when in_valid is high.
  - Stage 2: out_valid <= v1. When v1 is high, data_out, syndrome and err are loaded from r1.
- When en is low, all pipeline registers hold their values.
- Word loaded into the output register (en & v1) with nonzero syndrome:
  - err_count increments by 1, saturating at 2^CNT_W-1.
  - alarm sets to 1.
- clear has priority: err_count <= 0 and alarm <= 0. An erroneous word loaded in the same cycle is not counted and does not set alarm.
- The block only detects errors. No correction is made; data_out is always the received sum bits.

## Timing
- Reset values of all outputs are 0: out_valid, data_out, syndrome, err, err_count, alarm. Internal v1 and r1 also reset to 0. in_ready is therefore 1 in the first cycle after reset.
- Latency: a word accepted at edge N appears on the outputs after edge N+1 (out_valid=1), provided out_ready is not low in between.
- Throughput is one word per cycle while out_ready stays high.
- Backpressure: while out_valid=1 and out_ready=0, in_ready=0 and the outputs hold stable. No word is lost or duplicated.
- Bubbles (in_valid=0) propagate as out_valid=0 and never change err_count or alarm.
- A reset during operation drops all in-flight words immediately and clears the counter and alarm.
- err_count and alarm change on the same edge that loads the erroneous word into the output register.

## Test plan
- Reset and idle:
  - Stimulus: assert rst_n=0, then release with in_valid=0 for 10 cycles.
  - Response: all outputs 0, in_ready=1.
- Clean words:
  - Stimulus: send 15'h0000, then 15'h6881 (s=7'h01), with out_ready=1.
  - Response: out_valid on cycles N+1 and N+2; data_out=0x00 then 0x01; syndrome=0, err=0, err_count=0.
- Single-bit fault:
  - Stimulus: send 15'h6880 (bit 0 flipped).
  - Response: data_out=0x00, syndrome=8'hD1, err=1, err_count=1, alarm=1.
  - Stimulus: send 15'h6981 (bit 8 flipped).
  - Response: syndrome=8'h02, err_count=2.
- Backpressure:
  - Stimulus: stream 4 consecutive words, hold out_ready=0 for 3 cycles, then release.
  - Response: in_ready=0 and outputs stable while stalled; all 4 words delivered in order exactly once; count unchanged while stalled.
- Saturation and clear:
  - Stimulus: with CNT_W=2, send 5 faulty words.
  - Response: err_count stops at 3.
  - Stimulus: assert clear in the same cycle a faulty word loads.
  - Response: err_count=0, alarm=0.
- Asynchronous reset mid-stream:
  - Stimulus: drop rst_n off-edge while 2 words are in flight.
  - Response: outputs go to 0 immediately and no stale word appears after reset is released.
